cpu_mem: RTL and testbench
==========================

# cpu_mem

Memory-access pipeline stage: consumes the registered outputs of the execute stage, performs loads/stores over a request/acknowledge data bus with a bounded-wait FSM, and registers results for write-back. Stalls the upstream pipeline while an access is outstanding. Store data is forwarded from write-back and latched so that it remains stable for the whole access.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles spent waiting for `bus_ack` before the access is aborted. Legal range is 2..255.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `ex_c_rfw` in 1: register-file write enable of the instruction.
- `ex_c_wbsource` in 2: write-back source select. 00 = ALU, 01 = memory, 10 = jal return address.
- `ex_c_drw` in 1: store enable.
- `ex_alu_r` in 32: ALU result, which is also the memory address.
- `ex_rfb` in 32: store data.
- `ex_rf_waddr` in 5: destination register.
- `ex_jalra` in 32: return address.
- `ex_rt` in 5: store source register.
- `wb_wdata` in 32, `wb_rfw` in 1, `wb_waddr` in 5: write-back stage result, used for forwarding.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32, `bus_wdata` out 32: bus request.
- `bus_rdata` in 32, `bus_ack` in 1: bus response. `bus_ack` is a single-cycle pulse and is valid only while `bus_req` is high.
- `stall` out 1: holds the PC and the IF/ID/EX pipeline registers.
- `p_c_rfw` out 1, `p_c_wbsource` out 2, `p_alu_r` out 32, `p_dm_rdata` out 32, `p_rf_waddr` out 5, `p_jalra` out 32: registers to the write-back stage.
- `bus_err` out 1: one-cycle pulse on timeout.

## Operation
- Access condition: `acc = ex_c_drw | (ex_c_wbsource == 01)`.
- Forwarded store data is `fwd`:
  - `fwd = wb_wdata` when `wb_rfw & wb_waddr == ex_rt & wb_waddr != 0`.
  - Otherwise `fwd = ex_rfb`.
- FSM states are IDLE and WAIT.
- **IDLE:**
  - `bus_req = acc`, `bus_we = ex_c_drw`, `bus_addr = ex_alu_r`, `bus_wdata = fwd`.
  - `acc & bus_ack` (zero-wait): the access completes this cycle. `stall = 0` and the state stays IDLE.
  - `acc & ~bus_ack`: `stall = 1`. Latch `fwd` into `sdata_q`, clear the counter, go to WAIT.
  - `~acc`: no bus activity and `stall = 0`.
- **WAIT:**
  - `bus_req = 1`, with `bus_wdata = sdata_q`. `bus_addr` and `bus_we` come from the inputs, which upstream holds stable.
  - `bus_ack`: the access completes, `stall = 0`, go to IDLE.
  - Otherwise, if `cnt == TIMEOUT-1`: abort. Complete with `p_dm_rdata <= 0`, pulse `bus_err`, `stall = 0`, go to IDLE.
  - Otherwise: `cnt <= cnt + 1` and `stall = 1`.
- Pipeline registers:
  - When `stall = 0`, each `p_*` register loads its `ex_*` value at the edge.
  - On a completing load, `p_dm_rdata <= bus_rdata`. On a timeout, `p_dm_rdata <= 0`. For non-load instructions `p_dm_rdata` is held.
  - When `stall = 1`, a bubble is inserted: `p_c_rfw <= 0`, and the other `p_*` registers hold.
- A store with `ex_c_rfw = 1` is passed through unchanged. The stage performs no decode checks.

## Timing
- Reset: state IDLE, `cnt = 0`, `sdata_q = 0`. Every `p_*` output, `bus_err` and all bus outputs are 0, and `stall = 0`.
- Latency for a non-memory instruction or a zero-wait access: 1 cycle, with no stall.
- An access acknowledged N cycles after first request stalls for N cycles.
- Timeout: `stall` is high for exactly `TIMEOUT` cycles, counting the IDLE cycle plus `TIMEOUT-1` WAIT cycles. `bus_err` is high on the edge that completes the abort, for one cycle.
- `bus_ack` and the timeout in the same cycle: the ack wins, the data is valid and there is no error.
- `bus_ack` while `bus_req = 0`: ignored.
- Back-to-back accesses: the next access issues its request in the cycle immediately after the previous one completes. There is no dead cycle.
- `rst` asserted mid-WAIT: immediate return to IDLE, `bus_req` drops asynchronously, and the access is abandoned.

## Structure
- The shared `cpu_pkg` holds:
  - the write-back source encodings (`WB_ALU`, `WB_MEM`, `WB_JAL`);
  - the MEM FSM state encoding.
- One sub-module, `mem_wait_ctr`, is the natural split. It is a counter with clear/enable inputs and a terminal-count output, parameterised by `TIMEOUT`.

## Test plan
- Zero-wait load: `ex_alu_r = 0x100`, wbsource 01, `bus_ack` in the same cycle with `bus_rdata = 0xDEADBEEF`. Expect `stall` never high and `p_dm_rdata = 0xDEADBEEF` after one edge.
- Store with forwarding and 3 wait cycles: `ex_rt = 5`, `wb_waddr = 5`, `wb_wdata = 0x1234` in the first cycle only, and `bus_ack` on the 4th cycle. Expect `bus_wdata = 0x1234` for all 4 cycles and `stall` high for 3 cycles.
- Timeout with `TIMEOUT = 4`: load with no ack. Expect `stall` high for 4 cycles, then `bus_err` pulsed once, `p_dm_rdata = 0` and `p_c_rfw = 1`.
- Ack coincident with the terminal count: expect the data captured and `bus_err = 0`.
- `rst` asserted 2 cycles into WAIT: expect `bus_req` and all `p_*` outputs at 0 immediately, and the state IDLE after release.
- ALU instruction followed by back-to-back load/store pair: expect ALU pass-through with no stall, and bubbles (`p_c_rfw = 0`) inserted only during the wait cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU pipeline stages.
//   - write-back source select encodings (WB_ALU / WB_MEM / WB_JAL)
//   - MEM stage bus-access FSM state encoding
//   - width of the MEM stage wait counter (covers TIMEOUT up to 255)
package cpu_pkg;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_JAL = 2'b10;

   localparam int MEM_CNT_W = 8;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_t;

endpackage

// File: rtl/mem_wait_ctr.sv
// mem_wait_ctr: cycle counter for the MEM stage bounded bus wait.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (takes priority over en)
//   en       : increment by one
//   tc       : terminal count, high while the count equals TIMEOUT-1
module mem_wait_ctr
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [MEM_CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + MEM_CNT_W'(1);
   end

   assign tc = (cnt == MEM_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_mem.sv
// cpu_mem: memory-access pipeline stage.
// Takes the registered execute-stage outputs, performs loads/stores over a
// req/ack bus with a bounded wait, and registers results for write-back.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   ex_*                           : execute-stage instruction fields
//   wb_wdata, wb_rfw, wb_waddr     : write-back result, for store-data forwarding
//   bus_req/we/addr/wdata (out)    : bus request
//   bus_rdata, bus_ack (in)        : bus response, ack is a one-cycle pulse
//   stall                          : freezes PC and IF/ID/EX registers
//   p_*                            : registers feeding the write-back stage
//   bus_err                        : one-cycle pulse after an access times out
module cpu_mem
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_c_rfw,
   input  logic [1:0]  ex_c_wbsource,
   input  logic        ex_c_drw,
   input  logic [31:0] ex_alu_r,
   input  logic [31:0] ex_rfb,
   input  logic [4:0]  ex_rf_waddr,
   input  logic [31:0] ex_jalra,
   input  logic [4:0]  ex_rt,
   input  logic [31:0] wb_wdata,
   input  logic        wb_rfw,
   input  logic [4:0]  wb_waddr,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        stall,
   output logic        p_c_rfw,
   output logic [1:0]  p_c_wbsource,
   output logic [31:0] p_alu_r,
   output logic [31:0] p_dm_rdata,
   output logic [4:0]  p_rf_waddr,
   output logic [31:0] p_jalra,
   output logic        bus_err
);

   mem_state_t  state_q, state_d;
   logic [31:0] sdata_q;
   logic [31:0] fwd;
   logic        acc, is_load;
   logic        req_c, we_c, stall_c;
   logic [31:0] wdata_c;
   logic        latch_c, done_c, abort_c, cnt_clr, cnt_en, cnt_tc;

   assign is_load = (ex_c_wbsource == WB_MEM);
   assign acc     = ex_c_drw | is_load;
   assign fwd     = (wb_rfw && wb_waddr == ex_rt && wb_waddr != 5'd0) ? wb_wdata : ex_rfb;

   mem_wait_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .tc  (cnt_tc)
   );

   always_comb begin
      state_d = state_q;
      req_c   = 1'b0;
      we_c    = 1'b0;
      wdata_c = fwd;
      stall_c = 1'b0;
      latch_c = 1'b0;
      done_c  = 1'b0;
      abort_c = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         MEM_IDLE: begin
            req_c = acc;
            we_c  = ex_c_drw;
            if (acc) begin
               if (bus_ack) begin
                  done_c = 1'b1;
               end else begin
                  stall_c = 1'b1;
                  latch_c = 1'b1;
                  cnt_clr = 1'b1;
                  state_d = MEM_WAIT;
               end
            end
         end
         MEM_WAIT: begin
            req_c   = 1'b1;
            we_c    = ex_c_drw;
            wdata_c = sdata_q;
            // ack is checked before the terminal count so a late ack still wins
            if (bus_ack) begin
               done_c  = 1'b1;
               state_d = MEM_IDLE;
            end else if (cnt_tc) begin
               abort_c = 1'b1;
               state_d = MEM_IDLE;
            end else begin
               cnt_en  = 1'b1;
               stall_c = 1'b1;
            end
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   // Bus and stall are gated by rst so they drop immediately, without
   // waiting for the (possibly still active) execute-stage inputs to change.
   assign bus_req   = req_c & ~rst;
   assign bus_we    = we_c & ~rst;
   assign bus_addr  = rst ? 32'd0 : ex_alu_r;
   assign bus_wdata = rst ? 32'd0 : wdata_c;
   assign stall     = stall_c & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MEM_IDLE;
         sdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (latch_c)
            sdata_q <= fwd;
      end
   end

   // MEM -> WB pipeline boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_c_rfw      <= 1'b0;
         p_c_wbsource <= 2'b00;
         p_alu_r      <= 32'd0;
         p_dm_rdata   <= 32'd0;
         p_rf_waddr   <= 5'd0;
         p_jalra      <= 32'd0;
         bus_err      <= 1'b0;
      end else begin
         bus_err <= abort_c;
         if (stall_c) begin
            p_c_rfw <= 1'b0;
         end else begin
            p_c_rfw      <= ex_c_rfw;
            p_c_wbsource <= ex_c_wbsource;
            p_alu_r      <= ex_alu_r;
            p_rf_waddr   <= ex_rf_waddr;
            p_jalra      <= ex_jalra;
            if (abort_c)
               p_dm_rdata <= 32'd0;
            else if (done_c && is_load)
               p_dm_rdata <= bus_rdata;
         end
      end
   end

endmodule

// File: tb/tb_cpu_mem.sv
// tb_cpu_mem: directed, table-driven bench for cpu_mem with TIMEOUT = 4.
module tb_cpu_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_c_rfw;
   logic [1:0]  ex_c_wbsource;
   logic        ex_c_drw;
   logic [31:0] ex_alu_r;
   logic [31:0] ex_rfb;
   logic [4:0]  ex_rf_waddr;
   logic [31:0] ex_jalra;
   logic [4:0]  ex_rt;
   logic [31:0] wb_wdata;
   logic        wb_rfw;
   logic [4:0]  wb_waddr;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic        bus_ack;
   logic        stall;
   logic        p_c_rfw;
   logic [1:0]  p_c_wbsource;
   logic [31:0] p_alu_r, p_dm_rdata, p_jalra;
   logic [4:0]  p_rf_waddr;
   logic        bus_err;

   cpu_mem #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .ex_c_rfw(ex_c_rfw), .ex_c_wbsource(ex_c_wbsource), .ex_c_drw(ex_c_drw),
      .ex_alu_r(ex_alu_r), .ex_rfb(ex_rfb), .ex_rf_waddr(ex_rf_waddr),
      .ex_jalra(ex_jalra), .ex_rt(ex_rt),
      .wb_wdata(wb_wdata), .wb_rfw(wb_rfw), .wb_waddr(wb_waddr),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .stall(stall),
      .p_c_rfw(p_c_rfw), .p_c_wbsource(p_c_wbsource), .p_alu_r(p_alu_r),
      .p_dm_rdata(p_dm_rdata), .p_rf_waddr(p_rf_waddr), .p_jalra(p_jalra),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rfw;
      logic [1:0]  wbs;
      logic        drw;
      logic [31:0] alu;
      logic [31:0] rfb;
      logic [4:0]  rt;
      logic        wbrfw;
      logic [4:0]  wbwa;
      logic [31:0] wbwd;
      logic        ack;
      logic [31:0] rdata;
      logic        e_stall;
      logic        e_req;
      logic        e_we;
      logic [31:0] e_wdata;
      logic        e_prfw;
      logic [31:0] e_palu;
      logic [31:0] e_pdm;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_mis = 0;

   function automatic vec_t mk(
      logic rfw, logic [1:0] wbs, logic drw, logic [31:0] alu, logic [31:0] rfb,
      logic [4:0] rt, logic wbrfw, logic [4:0] wbwa, logic [31:0] wbwd,
      logic ack, logic [31:0] rdata,
      logic e_stall, logic e_req, logic e_we, logic [31:0] e_wdata,
      logic e_prfw, logic [31:0] e_palu, logic [31:0] e_pdm, logic e_err);
      vec_t v;
      v.rfw = rfw; v.wbs = wbs; v.drw = drw; v.alu = alu; v.rfb = rfb; v.rt = rt;
      v.wbrfw = wbrfw; v.wbwa = wbwa; v.wbwd = wbwd; v.ack = ack; v.rdata = rdata;
      v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we; v.e_wdata = e_wdata;
      v.e_prfw = e_prfw; v.e_palu = e_palu; v.e_pdm = e_pdm; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      ex_c_rfw      = v.rfw;
      ex_c_wbsource = v.wbs;
      ex_c_drw      = v.drw;
      ex_alu_r      = v.alu;
      ex_rfb        = v.rfb;
      ex_rt         = v.rt;
      wb_rfw        = v.wbrfw;
      wb_waddr      = v.wbwa;
      wb_wdata      = v.wbwd;
      bus_ack       = v.ack;
      bus_rdata     = v.rdata;
      ex_rf_waddr   = 5'd9;
      ex_jalra      = 32'd0;
   endtask

   initial begin
      //       rfw wbs    drw alu        rfb        rt  wbrfw wbwa wbwd       ack rdata         stall req we wdata      prfw palu       pdm           err
      vecs.push_back(mk(1, 2'b00, 0, 32'h55,  32'h0,    0, 0, 0, 32'h0,    0, 32'h0,         0, 0, 0, 32'h0,    1, 32'h55,  32'h0,        0)); // ALU pass
      vecs.push_back(mk(1, 2'b01, 0, 32'h100, 32'h0,    0, 0, 0, 32'h0,    1, 32'hDEADBEEF,  0, 1, 0, 32'h0,    1, 32'h100, 32'hDEADBEEF, 0)); // zero-wait load
      vecs.push_back(mk(1, 2'b00, 0, 32'h77,  32'h0,    0, 0, 0, 32'h0,    1, 32'h1111,      0, 0, 0, 32'h0,    1, 32'h77,  32'hDEADBEEF, 0)); // stray ack
      vecs.push_back(mk(0, 2'b00, 1, 32'h200, 32'hAAAA, 5, 1, 5, 32'h1234, 0, 32'h0,         1, 1, 1, 32'h1234, 0, 32'h77,  32'hDEADBEEF, 0)); // fwd store
      vecs.push_back(mk(0, 2'b00, 1, 32'h200, 32'hAAAA, 5, 0, 5, 32'h9999, 0, 32'h0,         1, 1, 1, 32'h1234, 0, 32'h77,  32'hDEADBEEF, 0));
      vecs.push_back(mk(0, 2'b00, 1, 32'h200, 32'hAAAA, 5, 0, 5, 32'h9999, 0, 32'h0,         1, 1, 1, 32'h1234, 0, 32'h77,  32'hDEADBEEF, 0));
      vecs.push_back(mk(0, 2'b00, 1, 32'h200, 32'hAAAA, 5, 0, 5, 32'h9999, 1, 32'h0,         0, 1, 1, 32'h1234, 0, 32'h200, 32'hDEADBEEF, 0));
      vecs.push_back(mk(1, 2'b01, 0, 32'h300, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,         1, 1, 0, 32'h0,    0, 32'h200, 32'hDEADBEEF, 0)); // b2b load
      vecs.push_back(mk(1, 2'b01, 0, 32'h300, 32'h0,    0, 0, 0, 32'h0,    1, 32'hCAFEF00D,  0, 1, 0, 32'h0,    1, 32'h300, 32'hCAFEF00D, 0));
      vecs.push_back(mk(0, 2'b00, 1, 32'h304, 32'h42,   6, 1, 0, 32'hBAD,  0, 32'h0,         1, 1, 1, 32'h42,   0, 32'h300, 32'hCAFEF00D, 0)); // b2b store, r0 no fwd
      vecs.push_back(mk(0, 2'b00, 1, 32'h304, 32'h42,   6, 1, 0, 32'hBAD,  1, 32'h0,         0, 1, 1, 32'h42,   0, 32'h304, 32'hCAFEF00D, 0));
      vecs.push_back(mk(1, 2'b00, 1, 32'h308, 32'h99,   2, 1, 3, 32'h777,  1, 32'h0,         0, 1, 1, 32'h99,   1, 32'h308, 32'hCAFEF00D, 0)); // store with rfw
      vecs.push_back(mk(1, 2'b01, 0, 32'h400, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,         1, 1, 0, 32'h0,    0, 32'h308, 32'hCAFEF00D, 0)); // timeout load
      vecs.push_back(mk(1, 2'b01, 0, 32'h400, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,         1, 1, 0, 32'h0,    0, 32'h308, 32'hCAFEF00D, 0));
      vecs.push_back(mk(1, 2'b01, 0, 32'h400, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,         1, 1, 0, 32'h0,    0, 32'h308, 32'hCAFEF00D, 0));
      vecs.push_back(mk(1, 2'b01, 0, 32'h400, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,         1, 1, 0, 32'h0,    0, 32'h308, 32'hCAFEF00D, 0));
      vecs.push_back(mk(1, 2'b01, 0, 32'h400, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,         0, 1, 0, 32'h0,    1, 32'h400, 32'h0,        1)); // abort
      vecs.push_back(mk(0, 2'b00, 0, 32'h0,   32'h0,    0, 0, 0, 32'h0,    0, 32'h0,         0, 0, 0, 32'h0,    0, 32'h0,   32'h0,        0)); // err drops
      vecs.push_back(mk(1, 2'b01, 0, 32'h500, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,         1, 1, 0, 32'h0,    0, 32'h0,   32'h0,        0)); // ack at tc
      vecs.push_back(mk(1, 2'b01, 0, 32'h500, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,         1, 1, 0, 32'h0,    0, 32'h0,   32'h0,        0));
      vecs.push_back(mk(1, 2'b01, 0, 32'h500, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,         1, 1, 0, 32'h0,    0, 32'h0,   32'h0,        0));
      vecs.push_back(mk(1, 2'b01, 0, 32'h500, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,         1, 1, 0, 32'h0,    0, 32'h0,   32'h0,        0));
      vecs.push_back(mk(1, 2'b01, 0, 32'h500, 32'h0,    0, 0, 0, 32'h0,    1, 32'h5A5A5A5A,  0, 1, 0, 32'h0,    1, 32'h500, 32'h5A5A5A5A, 0));
      vecs.push_back(mk(0, 2'b00, 0, 32'h123, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,         0, 0, 0, 32'h0,    0, 32'h123, 32'h5A5A5A5A, 0));

      // reset with a load presented: outputs must all be zero
      rst = 1'b1;
      drive(mk(1, 2'b01, 1, 32'hABC, 32'h77, 0, 0, 0, 32'h0, 0, 32'h0,
               0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
      #2;
      n_vec++;
      chk("rst bus_req", 32'(bus_req), 32'd0);
      chk("rst bus_we", 32'(bus_we), 32'd0);
      chk("rst bus_addr", bus_addr, 32'd0);
      chk("rst bus_wdata", bus_wdata, 32'd0);
      chk("rst stall", 32'(stall), 32'd0);
      chk("rst p_c_rfw", 32'(p_c_rfw), 32'd0);
      chk("rst p_alu_r", p_alu_r, 32'd0);
      chk("rst p_dm_rdata", p_dm_rdata, 32'd0);
      chk("rst p_jalra", p_jalra, 32'd0);
      chk("rst bus_err", 32'(bus_err), 32'd0);

      // jal instruction: check the side fields pass through
      @(negedge clk);
      rst = 1'b0;
      drive(mk(1, 2'b10, 0, 32'h2000, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0,
               0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
      ex_rf_waddr = 5'd31;
      ex_jalra    = 32'h1004;
      @(posedge clk); #1;
      n_vec++;
      chk("jal p_c_wbsource", 32'(p_c_wbsource), 32'd2);
      chk("jal p_rf_waddr", 32'(p_rf_waddr), 32'd31);
      chk("jal p_jalra", p_jalra, 32'h1004);
      chk("jal p_c_rfw", 32'(p_c_rfw), 32'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         n_vec++;
         chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
         chk($sformatf("v%0d bus_req", i), 32'(bus_req), 32'(vecs[i].e_req));
         chk($sformatf("v%0d bus_we", i), 32'(bus_we), 32'(vecs[i].e_we));
         chk($sformatf("v%0d bus_addr", i), bus_addr, vecs[i].alu);
         chk($sformatf("v%0d bus_wdata", i), bus_wdata, vecs[i].e_wdata);
         @(posedge clk); #1;
         chk($sformatf("v%0d p_c_rfw", i), 32'(p_c_rfw), 32'(vecs[i].e_prfw));
         chk($sformatf("v%0d p_alu_r", i), p_alu_r, vecs[i].e_palu);
         chk($sformatf("v%0d p_dm_rdata", i), p_dm_rdata, vecs[i].e_pdm);
         chk($sformatf("v%0d bus_err", i), 32'(bus_err), 32'(vecs[i].e_err));
      end

      // reset two cycles into WAIT
      @(negedge clk);
      drive(mk(1, 2'b01, 0, 32'h600, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0,
               0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
      @(posedge clk);
      @(posedge clk);
      @(posedge clk); #1;
      n_vec++;
      chk("wait bus_req", 32'(bus_req), 32'd1);
      chk("wait stall", 32'(stall), 32'd1);
      #2 rst = 1'b1;
      #1;
      n_vec++;
      chk("midrst bus_req", 32'(bus_req), 32'd0);
      chk("midrst stall", 32'(stall), 32'd0);
      chk("midrst bus_addr", bus_addr, 32'd0);
      chk("midrst p_alu_r", p_alu_r, 32'd0);
      chk("midrst p_dm_rdata", p_dm_rdata, 32'd0);
      chk("midrst p_c_rfw", 32'(p_c_rfw), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(mk(1, 2'b00, 0, 32'h700, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0,
               0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
      #1;
      n_vec++;
      chk("postrst bus_req", 32'(bus_req), 32'd0);
      chk("postrst stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      chk("postrst p_c_rfw", 32'(p_c_rfw), 32'd1);
      chk("postrst p_alu_r", p_alu_r, 32'h700);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
